// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: sequencer state encoding, forwarding select codes, XZR index and a register-match helper.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] XZR = 5'd31;

    // XZR reads as zero and discards writes, so it can never create a dependency.
    function automatic logic reg_hit(input logic [4:0] rw, input logic [4:0] rs);
        return (rw == rs) && (rw != XZR);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline register/stage signals seen by the hazard controller
// Purpose: bundles the stage inputs and the pipeline control outputs.
// slave  : the controller (reads stage info, drives enables/flush/bubble/fwd/counters)
// master : the pipeline datapath / testbench (drives stage info, reads controls)
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rn, id_rm;
    logic             id_uses_rn, id_uses_rm;
    logic             id_is_mul;
    logic [4:0]       ex_rn, ex_rm, ex_rw;
    logic             ex_mem_read;
    logic [4:0]       mem_rw, wb_rw;
    logic             mem_reg_write, wb_reg_write;
    logic             mem_br_taken;

    logic             pc_we, if_id_we, id_ex_we;
    logic             if_id_flush, id_ex_bubble, ex_mem_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_mul,
        input  ex_rn, ex_rm, ex_rw, ex_mem_read,
        input  mem_rw, wb_rw, mem_reg_write, wb_reg_write, mem_br_taken,
        output pc_we, if_id_we, id_ex_we,
        output if_id_flush, id_ex_bubble, ex_mem_bubble,
        output fwd_a, fwd_b, stall_cycles, flush_count
    );

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_mul,
        output ex_rn, ex_rm, ex_rw, ex_mem_read,
        output mem_rw, wb_rw, mem_reg_write, wb_reg_write, mem_br_taken,
        input  pc_we, if_id_we, id_ex_we,
        input  if_id_flush, id_ex_bubble, ex_mem_bubble,
        input  fwd_a, fwd_b, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - EX operand forwarding select for one source register
// Ports: i_ex_rs source in EX; i_mem_rw/i_mem_reg_write and i_wb_rw/i_wb_reg_write producers;
//        o_fwd_sel operand select (FWD_REG / FWD_MEM / FWD_WB).
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_mem_rw,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rw,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_fwd_sel
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        o_fwd_sel = FWD_REG;
        if (i_mem_reg_write && reg_hit(i_mem_rw, i_ex_rs)) begin
            o_fwd_sel = FWD_MEM;
        end else if (i_wb_reg_write && reg_hit(i_wb_rw, i_ex_rs)) begin
            o_fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline stall/flush/forward controller
// Ports: clk, reset (async, active-high); hz (slave) carries stage info in and
//        PC/pipeline-register controls, forwarding selects and perf counters out.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_hazard_ctrl_if.slave     hz
);

    localparam logic [3:0] LP_HOLD = 4'(MULT_LAT - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic       w_load_use;
    logic       w_pc_we, w_if_id_we, w_id_ex_we;
    logic       w_if_id_flush, w_id_ex_bubble, w_ex_mem_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_load_use = hz.ex_mem_read &&
                        ((hz.id_uses_rn && reg_hit(hz.ex_rw, hz.id_rn)) ||
                         (hz.id_uses_rm && reg_hit(hz.ex_rw, hz.id_rm)));

    fwd_unit u_fwd_a (
        .i_ex_rs         (hz.ex_rn),
        .i_mem_rw        (hz.mem_rw),
        .i_mem_reg_write (hz.mem_reg_write),
        .i_wb_rw         (hz.wb_rw),
        .i_wb_reg_write  (hz.wb_reg_write),
        .o_fwd_sel       (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_ex_rs         (hz.ex_rm),
        .i_mem_rw        (hz.mem_rw),
        .i_mem_reg_write (hz.mem_reg_write),
        .i_wb_rw         (hz.wb_rw),
        .i_wb_reg_write  (hz.wb_reg_write),
        .o_fwd_sel       (w_fwd_b)
    );

    // Priority: reset, branch flush, multiply hold, load-use stall.
    always_comb begin
        w_pc_we         = 1'b1;
        w_if_id_we      = 1'b1;
        w_id_ex_we      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        if (reset) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_id_ex_we = 1'b0;
        end else if (hz.mem_br_taken) begin
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else if (r_state == MUL_WAIT) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_bubble = 1'b1;
        end else if (w_load_use) begin
            w_pc_we        = 1'b0;
            w_if_id_we     = 1'b0;
            w_id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_cnt          <= 4'd0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (hz.mem_br_taken) begin
                r_state <= RUN;
                r_cnt   <= 4'd0;
                if (r_flush_count != '1) begin
                    r_flush_count <= r_flush_count + 1'b1;
                end
            end else if (r_state == MUL_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                // Leave on the cycle cnt lands on zero; <= also guards a stray zero.
                if (r_cnt <= 4'd1) begin
                    r_state <= RUN;
                end
            end else if (hz.id_is_mul && !w_load_use && (MULT_LAT > 1)) begin
                r_state <= MUL_WAIT;
                r_cnt   <= LP_HOLD;
            end

            if (!w_pc_we && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign hz.pc_we         = w_pc_we;
    assign hz.if_id_we      = w_if_id_we;
    assign hz.id_ex_we      = w_id_ex_we;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.id_ex_bubble  = w_id_ex_bubble;
    assign hz.ex_mem_bubble = w_ex_mem_bubble;
    assign hz.fwd_a         = reset ? FWD_REG : w_fwd_a;
    assign hz.fwd_b         = reset ? FWD_REG : w_fwd_b;
    assign hz.stall_cycles  = r_stall_cycles;
    assign hz.flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MULT_LAT(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble, fwd_a, fwd_b}
    logic [9:0] ctl;
    assign ctl = {hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.if_id_flush, hz.id_ex_bubble,
                  hz.ex_mem_bubble, hz.fwd_a, hz.fwd_b};

    localparam logic [9:0] C_RUN   = 10'b111_000_00_00;
    localparam logic [9:0] C_LU    = 10'b001_010_00_00;
    localparam logic [9:0] C_HOLD  = 10'b000_001_00_00;
    localparam logic [9:0] C_FLUSH = 10'b111_111_00_00;

    typedef struct {
        string      name;
        logic [4:0] id_rn, id_rm;
        logic       uses_rn, uses_rm;
        logic [4:0] ex_rn, ex_rm, ex_rw;
        logic       ld;
        logic [4:0] mem_rw;
        logic       mem_we;
        logic [4:0] wb_rw;
        logic       wb_we;
        logic       br;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[11];

    int n_pass  = 0;
    int n_total = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm,
                                input logic [4:0] id_rn, input logic [4:0] id_rm,
                                input logic uses_rn, input logic uses_rm,
                                input logic [4:0] ex_rn, input logic [4:0] ex_rm,
                                input logic [4:0] ex_rw, input logic ld,
                                input logic [4:0] mem_rw, input logic mem_we,
                                input logic [4:0] wb_rw, input logic wb_we,
                                input logic br, input logic [9:0] exp);
        vec_t v;
        v.name = nm; v.id_rn = id_rn; v.id_rm = id_rm; v.uses_rn = uses_rn; v.uses_rm = uses_rm;
        v.ex_rn = ex_rn; v.ex_rm = ex_rm; v.ex_rw = ex_rw; v.ld = ld;
        v.mem_rw = mem_rw; v.mem_we = mem_we; v.wb_rw = wb_rw; v.wb_we = wb_we;
        v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic quiet();
        hz.id_rn = 5'd0; hz.id_rm = 5'd0; hz.id_uses_rn = 1'b0; hz.id_uses_rm = 1'b0;
        hz.id_is_mul = 1'b0; hz.ex_rn = 5'd0; hz.ex_rm = 5'd0; hz.ex_rw = 5'd0;
        hz.ex_mem_read = 1'b0; hz.mem_rw = 5'd0; hz.wb_rw = 5'd0;
        hz.mem_reg_write = 1'b0; hz.wb_reg_write = 1'b0; hz.mem_br_taken = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hz.id_rn = v.id_rn; hz.id_rm = v.id_rm; hz.id_uses_rn = v.uses_rn; hz.id_uses_rm = v.uses_rm;
        hz.id_is_mul = 1'b0; hz.ex_rn = v.ex_rn; hz.ex_rm = v.ex_rm; hz.ex_rw = v.ex_rw;
        hz.ex_mem_read = v.ld; hz.mem_rw = v.mem_rw; hz.mem_reg_write = v.mem_we;
        hz.wb_rw = v.wb_rw; hz.wb_reg_write = v.wb_we; hz.mem_br_taken = v.br;
    endtask

    initial begin
        //            name        idrn idrm urn urm exrn exrm exrw ld memrw mwe wbrw wwe br exp
        vecs[0]  = mk("idle",      0,   0,  0,  0,  0,   0,   0,  0,  0,   0,  0,   0,  0, C_RUN);
        vecs[1]  = mk("lu_rn",     1,   2,  1,  0,  3,   4,   1,  1,  0,   0,  0,   0,  0, C_LU);
        vecs[2]  = mk("lu_xzr",   31,   2,  1,  0,  0,   0,  31,  1,  0,   0,  0,   0,  0, C_RUN);
        vecs[3]  = mk("lu_rm",     6,   4,  0,  1,  0,   0,   4,  1,  0,   0,  0,   0,  0, C_LU);
        vecs[4]  = mk("lu_unused", 8,   0,  0,  0,  0,   0,   8,  1,  0,   0,  0,   0,  0, C_RUN);
        vecs[5]  = mk("fwd_mem_pri",0,  0,  0,  0,  5,   7,   0,  0,  5,   1,  5,   1,  0, 10'b111_000_01_00);
        vecs[6]  = mk("fwd_wb",    0,   0,  0,  0,  5,   7,   0,  0,  5,   0,  5,   1,  0, 10'b111_000_10_00);
        vecs[7]  = mk("fwd_split", 0,   0,  0,  0,  3,   9,   0,  0,  9,   1,  3,   1,  0, 10'b111_000_10_01);
        vecs[8]  = mk("fwd_xzr",   0,   0,  0,  0, 31,  31,   0,  0, 31,   1, 31,   1,  0, C_RUN);
        vecs[9]  = mk("br_over_lu",1,   0,  1,  0,  0,   0,   1,  1,  0,   0,  0,   0,  1, C_FLUSH);
        vecs[10] = mk("br_fwd",    0,   0,  0,  0,  2,   0,   0,  0,  2,   1,  0,   0,  1, 10'b111_111_01_00);

        // Reset with a live forwarding match: everything must read zero.
        quiet();
        hz.ex_rn = 5'd5; hz.mem_rw = 5'd5; hz.mem_reg_write = 1'b1;
        reset = 1'b1;
        #7;
        check("reset_ctl", 64'(ctl), 64'(10'd0));
        check("reset_stall", 64'(hz.stall_cycles), 64'd0);
        check("reset_flush", 64'(hz.flush_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet();

        // Table vectors: all stay in RUN, counters tracked from the expected controls.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            #1;
            check(vecs[i].name, 64'(ctl), 64'(vecs[i].exp));
            if (!vecs[i].exp[9]) exp_stall++;
            if (vecs[i].br) exp_flush++;
            @(negedge clk);
        end
        quiet();
        #1;
        check("tbl_stall_cnt", 64'(hz.stall_cycles), 64'(exp_stall));
        check("tbl_flush_cnt", 64'(hz.flush_count), 64'(exp_flush));

        // Multiply: one RUN cycle issues it, then MULT_LAT-1 = 3 hold cycles.
        @(negedge clk);
        hz.id_is_mul = 1'b1;
        #1 check("mul_issue", 64'(ctl), 64'(C_RUN));
        @(negedge clk);
        hz.id_is_mul = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("mul_hold%0d", k), 64'(ctl), 64'(C_HOLD));
            @(negedge clk);
        end
        exp_stall += 3;
        #1;
        check("mul_done", 64'(ctl), 64'(C_RUN));
        check("mul_stall_cnt", 64'(hz.stall_cycles), 64'(exp_stall));

        // Branch while holding with cnt=2: flush wins, pipe resumes next cycle.
        @(negedge clk);
        hz.id_is_mul = 1'b1;
        @(negedge clk);
        hz.id_is_mul = 1'b0;
        #1 check("brh_hold", 64'(ctl), 64'(C_HOLD));
        @(negedge clk);
        exp_stall += 1;
        hz.mem_br_taken = 1'b1;
        #1 check("brh_flush", 64'(ctl), 64'(C_FLUSH));
        @(negedge clk);
        hz.mem_br_taken = 1'b0;
        exp_flush += 1;
        #1;
        check("brh_run", 64'(ctl), 64'(C_RUN));
        check("brh_flush_cnt", 64'(hz.flush_count), 64'(exp_flush));
        check("brh_stall_cnt", 64'(hz.stall_cycles), 64'(exp_stall));

        // Async reset pulse between edges in the middle of a hold.
        @(negedge clk);
        hz.id_is_mul = 1'b1;
        @(negedge clk);
        hz.id_is_mul = 1'b0;
        #1 check("rst_pre_hold", 64'(ctl), 64'(C_HOLD));
        #1 reset = 1'b1;
        #1;
        check("rst_async_ctl", 64'(ctl), 64'(10'd0));
        check("rst_async_stall", 64'(hz.stall_cycles), 64'd0);
        check("rst_async_flush", 64'(hz.flush_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_release", 64'(ctl), 64'(C_RUN));
        @(negedge clk);
        #1;
        check("rst_run_after", 64'(ctl), 64'(C_RUN));
        check("rst_stall_after", 64'(hz.stall_cycles), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
